// File: rtl/pio_input_debounced.sv
// Avalon-MM input PIO: two-flop synchroniser, per-bit debounce, edge capture (W1C)
// and a maskable level interrupt. Read latency 1, readdata registered every cycle.
module pio_input_debounced #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_address,
    input  logic             i_chipselect,
    input  logic             i_read,
    input  logic             i_write,
    input  logic [31:0]      i_writedata,
    output logic [31:0]      o_readdata,
    input  logic [WIDTH-1:0] i_in_port,
    output logic             o_irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1, r_sync2, r_deb, r_deb_d;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_mask, r_edge;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_rise, w_fall, w_edge_set, w_edge_clr;
    logic             w_mask_we, w_edge_we;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    // Reads have no side effects; upper writedata bits are never stored.
    assign w_unused = i_read ^ (^i_writedata);

    assign w_rise = r_deb & ~r_deb_d;
    assign w_fall = ~r_deb & r_deb_d;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge_set = w_rise;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge_set = w_fall;
        end else begin : g_any
            assign w_edge_set = w_rise | w_fall;
        end
    endgenerate

    assign w_mask_we  = i_chipselect & i_write & (i_address == 2'd2);
    assign w_edge_we  = i_chipselect & i_write & (i_address == 2'd3);
    assign w_edge_clr = w_edge_we ? i_writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        unique case (i_address)
            2'd0:    w_rd_mux[WIDTH-1:0] = r_deb;
            2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
            2'd3:    w_rd_mux[WIDTH-1:0] = r_edge;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= i_in_port;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A new edge overrides a simultaneous W1C on the same bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mask     <= '0;
            r_edge     <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_mask_we) begin
                r_mask <= i_writedata[WIDTH-1:0];
            end
            r_edge     <= (r_edge & ~w_edge_clr) | w_edge_set;
            r_readdata <= w_rd_mux;
            r_irq      <= |(r_edge & r_mask);
        end
    end

    assign o_readdata = r_readdata;
    assign o_irq      = r_irq;

endmodule

// File: tb/tb_pio_input_debounced.sv
// Scoreboard bench for pio_input_debounced: three configurations share one bus, each with
// its own chipselect; expected reads/irq levels are queued and checked by a monitor.
module tb_pio_input_debounced;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  addr;
    logic [2:0]  cs;
    logic        rd, wr;
    logic [31:0] wdata;
    logic [7:0]  in0, in1;
    logic [31:0] in2;
    logic [31:0] rdata0, rdata1, rdata2;
    logic        irq0, irq1, irq2;

    pio_input_debounced #(.WIDTH(8), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0)) u_dut0 (
        .i_clk(clk), .i_reset(reset), .i_address(addr), .i_chipselect(cs[0]), .i_read(rd),
        .i_write(wr), .i_writedata(wdata), .o_readdata(rdata0), .i_in_port(in0), .o_irq(irq0)
    );
    pio_input_debounced #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_address(addr), .i_chipselect(cs[1]), .i_read(rd),
        .i_write(wr), .i_writedata(wdata), .o_readdata(rdata1), .i_in_port(in1), .o_irq(irq1)
    );
    pio_input_debounced #(.WIDTH(32), .DEBOUNCE_CYCLES(3), .EDGE_TYPE(2)) u_dut2 (
        .i_clk(clk), .i_reset(reset), .i_address(addr), .i_chipselect(cs[2]), .i_read(rd),
        .i_write(wr), .i_writedata(wdata), .o_readdata(rdata2), .i_in_port(in2), .o_irq(irq2)
    );

    typedef struct {
        int          dut;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t rd_q[$];
    exp_t irq_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rd_seen = 1'b0;
    logic irq_chk = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input int d, input logic [1:0] a, input logic [31:0] exp,
                            input string nm);
        exp_t e;
        e.dut = d; e.exp = exp; e.name = nm;
        rd_q.push_back(e);
        cs = '0; cs[d] = 1'b1; rd = 1'b1; addr = a;
        tick(1);
        cs = '0; rd = 1'b0;
    endtask

    task automatic bus_write(input int d, input logic [1:0] a, input logic [31:0] data);
        cs = '0; cs[d] = 1'b1; wr = 1'b1; addr = a; wdata = data;
        tick(1);
        cs = '0; wr = 1'b0;
    endtask

    task automatic check_irq(input int d, input logic exp, input string nm);
        exp_t e;
        e.dut = d; e.exp = {31'd0, exp}; e.name = nm;
        irq_q.push_back(e);
        irq_chk = 1'b1;
        tick(1);
        irq_chk = 1'b0;
    endtask

    always @(posedge clk) rd_seen <= rd && (cs != 3'b000);

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (rd_seen) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: readdata arrived with no expectation queued");
            end else begin
                e = rd_q.pop_front();
                act = (e.dut == 0) ? rdata0 : (e.dut == 1) ? rdata1 : rdata2;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: dut%0d readdata=%h expected %h", e.name, e.dut, act,
                             e.exp);
                end
            end
        end
        if (irq_chk) begin
            checks++;
            if (irq_q.size() == 0) begin
                errors++;
                $display("FAIL irq_unexpected: irq sample with no expectation queued");
            end else begin
                e = irq_q.pop_front();
                act = {31'd0, (e.dut == 0) ? irq0 : (e.dut == 1) ? irq1 : irq2};
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: dut%0d irq=%0d expected %0d", e.name, e.dut, act[0],
                             e.exp[0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; addr = '0; cs = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
        in0 = 8'hFF; in1 = '0; in2 = '0;

        // Reset held for two edges with all inputs high
        bus_read(0, 2'd0, 32'h0, "reset_readdata");
        check_irq(0, 1'b0, "reset_irq");
        reset = 1'b0;
        tick(17);
        bus_read(0, 2'd0, 32'h00, "data_before_latency");
        bus_read(0, 2'd0, 32'hFF, "data_after_latency");
        bus_read(0, 2'd3, 32'hFF, "edge_init_rise");
        check_irq(0, 1'b0, "irq_init_masked");
        bus_write(0, 2'd3, 32'hFF);
        bus_read(0, 2'd3, 32'h00, "edge_w1c_all");
        in0 = 8'h00;
        tick(22);
        bus_read(0, 2'd0, 32'h00, "data_low");
        bus_read(0, 2'd3, 32'h00, "no_fall_capture");

        // Glitch rejection: 15 cycles rejected, 16 accepted
        in0[0] = 1'b1; tick(15); in0[0] = 1'b0;
        tick(20);
        bus_read(0, 2'd0, 32'h00, "glitch15_rejected");
        in0[0] = 1'b1; tick(16); in0[0] = 1'b0;
        tick(4);
        bus_read(0, 2'd0, 32'h01, "pulse16_accepted");
        tick(30);
        bus_write(0, 2'd3, 32'hFF);
        bus_read(0, 2'd0, 32'h00, "pulse16_released");

        // Edge capture and irq with mask
        bus_write(0, 2'd2, 32'h01);
        in0[0] = 1'b1;
        tick(22);
        bus_read(0, 2'd3, 32'h01, "edge_bit0");
        check_irq(0, 1'b1, "irq_bit0");
        bus_write(0, 2'd3, 32'h01);
        check_irq(0, 1'b1, "irq_registered_after_w1c");
        check_irq(0, 1'b0, "irq_cleared");
        bus_read(0, 2'd3, 32'h00, "edge_bit0_cleared");

        // Masked edge, then unmask
        bus_write(0, 2'd2, 32'h00);
        in0 = 8'h09;
        tick(22);
        bus_read(0, 2'd3, 32'h08, "edge_bit3");
        check_irq(0, 1'b0, "irq_masked");
        bus_write(0, 2'd2, 32'h08);
        check_irq(0, 1'b0, "irq_mask_latency");
        check_irq(0, 1'b1, "irq_unmasked");
        bus_read(0, 2'd2, 32'h08, "mask_readback");
        bus_write(0, 2'd2, 32'hFFFF_FFFF);
        bus_read(0, 2'd2, 32'h0000_00FF, "mask_upper_zero");

        // Falling-edge config: W1C collides with a new falling edge on bit2
        in1[2] = 1'b1;
        tick(10);
        bus_read(1, 2'd3, 32'h00, "fall_cfg_ignores_rise");
        in1[2] = 1'b0;
        tick(6);
        bus_write(1, 2'd3, 32'h04);
        bus_read(1, 2'd3, 32'h04, "collision_set_wins");
        bus_write(1, 2'd3, 32'h04);
        bus_read(1, 2'd3, 32'h00, "w1c_bit2");

        // 32-bit any-edge config
        in2[31] = 1'b1;
        tick(8);
        bus_read(2, 2'd0, 32'h8000_0000, "data_bit31");
        bus_read(2, 2'd3, 32'h8000_0000, "edge_rise31");
        bus_write(2, 2'd3, 32'h8000_0000);
        bus_read(2, 2'd3, 32'h0000_0000, "edge31_cleared");
        in2[31] = 1'b0;
        tick(8);
        bus_read(2, 2'd3, 32'h8000_0000, "edge_fall31");
        bus_write(2, 2'd1, 32'hFFFF_FFFF);
        bus_read(2, 2'd1, 32'h0000_0000, "rsvd_reads_zero");
        bus_write(2, 2'd0, 32'hFFFF_FFFF);
        bus_read(2, 2'd0, 32'h0000_0000, "data_read_only");

        tick(3);
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d reads and %0d irq samples left, expected 0",
                     rd_q.size(), irq_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
